// File: rtl/alut_apb_pkg11.sv
// Shared types for the ALUT APB initiator: default widths, FSM states and
// the packed request word stored in the request FIFO.
package alut_apb_pkg11;

   localparam int ALUT_AW = 7;
   localparam int ALUT_DW = 32;
   localparam int ALUT_FD = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // FIFO payload: direction, address and write data of one APB transfer
   typedef struct packed {
      logic               write;
      logic [ALUT_AW-1:0] addr;
      logic [ALUT_DW-1:0] wdata;
   } apb_req_t;

   localparam int REQ_W = $bits(apb_req_t);

endpackage

// File: rtl/alut_req_fifo11.sv
// Synchronous request FIFO. Head is presented combinationally on dout.
// Occupancy counter (one bit wider than the pointers) gives full/empty;
// pointers wrap naturally because the depth is a power of two.
module alut_req_fifo11 #(
   parameter int W = 40,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(D);

   logic [W-1:0]  mem [D];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   // a push against a full FIFO or a pop of an empty one is ignored
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign full  = (count == (PW+1)'(D));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // storage array needs no reset: entries are only read once written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alut_apb_master11.sv
// APB initiator for the ALUT register bank. Requests are queued in a small
// FIFO and each one runs as a single SETUP+ACCESS transfer (the slave has no
// pready, so ACCESS is always one cycle). The result lands in a one-deep
// response register; a new transfer is not started while a response is
// still unconsumed, so the response register can never be overrun.
// The request struct is sized by the package defaults; AW/DW are expected
// to match them.
module alut_apb_master11
   import alut_apb_pkg11::*;
#(
   parameter int AW = ALUT_AW,
   parameter int DW = ALUT_DW,
   parameter int FD = ALUT_FD
) (
   input  logic          pclk11,
   input  logic          n_p_reset11,
   // request channel
   input  logic          req_valid11,
   output logic          req_ready11,
   input  logic          req_write11,
   input  logic [AW-1:0] req_addr11,
   input  logic [DW-1:0] req_wdata11,
   // response channel
   output logic          rsp_valid11,
   input  logic          rsp_ready11,
   output logic          rsp_write11,
   output logic [DW-1:0] rsp_rdata11,
   output logic          busy11,
   // APB
   output logic          psel11,
   output logic          penable11,
   output logic          pwrite11,
   output logic [AW-1:0] paddr11,
   output logic [DW-1:0] pwdata11,
   input  logic [DW-1:0] prdata11
);

   apb_state_e state;
   apb_req_t   req_in;
   apb_req_t   req_head;
   logic [REQ_W-1:0] fifo_dout;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_push;
   logic       fifo_pop;

   assign req_in.write = req_write11;
   assign req_in.addr  = ALUT_AW'(req_addr11);
   assign req_in.wdata = ALUT_DW'(req_wdata11);
   assign req_head     = apb_req_t'(fifo_dout);

   assign req_ready11 = ~fifo_full;
   assign fifo_push   = req_valid11 & ~fifo_full;
   // head leaves the FIFO on the same edge that enters SETUP
   assign fifo_pop    = (state == IDLE) & ~fifo_empty & ~rsp_valid11;

   assign busy11 = ~fifo_empty | (state != IDLE) | rsp_valid11;

   alut_req_fifo11 #(
      .W (REQ_W),
      .D (FD)
   ) u_fifo (
      .clk   (pclk11),
      .rst_n (n_p_reset11),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (req_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // transfer FSM with registered APB outputs and response register
   always_ff @(posedge pclk11 or negedge n_p_reset11) begin
      if (!n_p_reset11) begin
         state       <= IDLE;
         psel11      <= 1'b0;
         penable11   <= 1'b0;
         pwrite11    <= 1'b0;
         paddr11     <= '0;
         pwdata11    <= '0;
         rsp_valid11 <= 1'b0;
         rsp_write11 <= 1'b0;
         rsp_rdata11 <= '0;
      end else begin
         // consumer handshake; cannot collide with a set (see fifo_pop)
         if (rsp_valid11 && rsp_ready11) rsp_valid11 <= 1'b0;

         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  state     <= SETUP;
                  psel11    <= 1'b1;
                  penable11 <= 1'b0;
                  pwrite11  <= req_head.write;
                  paddr11   <= AW'(req_head.addr);
                  pwdata11  <= DW'(req_head.wdata);
               end
            end
            SETUP: begin
               state     <= ACCESS;
               penable11 <= 1'b1;
            end
            ACCESS: begin
               state       <= IDLE;
               psel11      <= 1'b0;
               penable11   <= 1'b0;
               rsp_valid11 <= 1'b1;
               rsp_write11 <= pwrite11;
               rsp_rdata11 <= pwrite11 ? '0 : prdata11;
            end
            default: begin
               state     <= IDLE;
               psel11    <= 1'b0;
               penable11 <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/alut_apb_master11.md
Name: alut_apb_master11

Overview:
- APB initiator that drives the ALUT register-bank slave (psel11/penable11/pwrite11/paddr11/pwdata11 out, prdata11 in).
- Accepts register read/write requests from a local controller (CPU bridge or test sequencer) over a valid/ready request channel and buffers them in a small FIFO.
- Runs each request as one APB SETUP+ACCESS transfer. Returns the read data, or a write acknowledge, on a valid/ready response channel.
- The slave has no pready/pslverr, so every ACCESS phase is exactly one cycle.

Parameters:
- AW, 7, APB address width (matches slave paddr11).
- DW, 32, APB data width.
- FD, 4, request FIFO depth (power of two, ≥2).

Ports:
- pclk11 in 1: APB clock, all logic on rising edge.
- n_p_reset11 in 1: reset, asynchronous, active-low.
- req_valid11 in 1: request present.
- req_ready11 out 1: FIFO can accept; equals !fifo_full.
- req_write11 in 1: 1 = write, 0 = read.
- req_addr11 in AW: register address.
- req_wdata11 in DW: write data (ignored for reads).
- rsp_valid11 out 1: response held in the response register.
- rsp_ready11 in 1: consumer takes the response.
- rsp_write11 out 1: response belongs to a write (ack).
- rsp_rdata11 out DW: captured prdata11 for reads; 0 for writes.
- busy11 out 1: FIFO non-empty, or FSM not IDLE, or rsp_valid11.
- psel11 out 1: APB select.
- penable11 out 1: APB enable.
- pwrite11 out 1: APB direction.
- paddr11 out AW: APB address.
- pwdata11 out DW: APB write data.
- prdata11 in DW: APB read data from slave.

Behaviour:
- Reset, asynchronous: psel11=0, penable11=0, pwrite11=0, paddr11=0, pwdata11=0, rsp_valid11=0, rsp_write11=0, rsp_rdata11=0, FIFO emptied (pointers 0), FSM=IDLE. busy11 therefore reads 0.
- Reset mid-transfer aborts immediately: psel11/penable11 drop in the same instant and the in-flight and queued requests are discarded, with no response.
- Request channel: push when req_valid11 & req_ready11. req_ready11 is combinational !full. Requesters hold their payload while valid and not ready.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE -> SETUP when FIFO non-empty and rsp_valid11=0. The same edge pops the FIFO head into pwrite11/paddr11/pwdata11 and sets psel11=1, penable11=0.
- IDLE stays in IDLE otherwise. A pending unconsumed response blocks the next transfer, so there is no response overrun.
- SETUP -> ACCESS unconditionally: penable11=1, address/data/direction stable.
- ACCESS -> IDLE unconditionally. On that edge psel11=0, penable11=0, and rsp_valid11=1, rsp_write11=pwrite11.
- rsp_rdata11 = prdata11 for reads, 0 for writes. paddr11/pwdata11/pwrite11 keep their last values while idle.
- Response channel: rsp_valid11 clears on an edge where rsp_ready11=1. A clear and a new set can never coincide, because a set requires rsp_valid11=0 at SETUP entry.
- Latency: request accepted in cycle 0 -> SETUP visible in cycle 2 -> ACCESS in cycle 3 -> rsp_valid11 in cycle 4 (rsp_ready11 tied 1).
- Throughput: back-to-back requests with rsp_ready11=1 produce one APB transfer every 4 cycles (IDLE, SETUP, ACCESS, response cycle); psel11 is never held across transfers.
- FIFO boundaries:
  - Push while full is impossible (ready low).
  - Push and pop in the same cycle when full: pop frees a slot, ready rises next cycle.
  - Push and pop in the same cycle when non-full: occupancy is unchanged.
  - Pointers wrap modulo FD; an occupancy counter of width log2(FD)+1 gives full/empty.
- Ordering is strictly FIFO. APB transfers occur in request order, with no reordering or merging.

Decomposition:
- Package alut_apb_pkg11 holds:
  - AW/DW defaults.
  - FSM state enum {IDLE, SETUP, ACCESS}.
  - Packed request struct {write, addr[AW], wdata[DW]} = 1+AW+DW bits, used as FIFO payload.
- One sub-module: alut_req_fifo11, a synchronous FIFO.
  - Parameters: width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - Same clock/reset.
- The top holds the FSM, APB registers and response register.

Test Plan:
- Reset: assert n_p_reset11 during an ACCESS phase -> psel11/penable11 go 0 asynchronously; after release busy11=0, rsp_valid11=0, req_ready11=1.
- Single write: addr 7'h08, data 32'hDEAD_BEEF at cycle 0 -> cycle 2 psel11=1 penable11=0 pwrite11=1 paddr11=08; cycle 3 penable11=1; cycle 4 rsp_valid11=1, rsp_write11=1, rsp_rdata11=0.
- Single read: addr 7'h1C, slave drives 32'h0000_0013 -> rsp_rdata11=32'h0000_0013, rsp_write11=0, rsp_valid11 in cycle 4.
- FIFO full: 5 requests with rsp_ready11=0 -> first issued, 4 queued, req_ready11=0. No second SETUP until rsp_ready11=1. Then the remaining 4 complete in order with correct addresses.
- Back-to-back with rsp_ready11=1: 3 writes then 1 read -> psel11 pulses exactly 4 times, 4 cycles apart, paddr11 sequence matches push order.
- Wrap-around: 10 alternating read/write requests through FD=4 -> all responses returned in order, data intact, no dropped or duplicated transfer.
